// File: rtl/fa_chk_pkg.sv
// Shared types and the full-adder reference model used by the response checker.
package fa_chk_pkg;

    typedef struct packed {
        logic a;
        logic b;
        logic ci;
    } fa_vec_t;

    typedef struct packed {
        logic cry;
        logic s;
    } fa_rsp_t;

    // Packs as {a,b,ci,cry,s}
    typedef struct packed {
        fa_vec_t vec;
        fa_rsp_t rsp;
    } fa_exp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } chk_state_e;

    // Golden full-adder behaviour.
    function automatic fa_rsp_t fa_ref(input fa_vec_t v);
        fa_rsp_t r;
        r.s   = v.a ^ v.b ^ v.ci;
        r.cry = (v.a & v.b) | (v.ci & (v.a ^ v.b));
        return r;
    endfunction

endpackage

// File: rtl/fa_exp_fifo.sv
// In-order queue of expected full-adder results awaiting a DUT response.
module fa_exp_fifo
    import fa_chk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    push,
    input  fa_exp_t push_data,
    input  logic    pop,
    output fa_exp_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    fa_exp_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // The extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer control; clr empties the queue at the start of every run.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fa_resp_checker.sv
// Response-side checker for a full adder: queues expected {cry,s} for each
// accepted stimulus and scores DUT responses against them in order.
module fa_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stim_vld,
    output logic             stim_rdy,
    input  logic             stim_a,
    input  logic             stim_b,
    input  logic             stim_ci,
    input  logic             rsp_vld,
    input  logic             rsp_s,
    input  logic             rsp_cry,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [4:0]       first_fail_vec,
    output logic             err,
    output logic             orphan_err,
    output logic             timeout_err,
    output logic             done
);

    localparam int               TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VECTORS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    chk_state_e       state;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] checked;
    logic [TMO_W-1:0] tmo_cnt;

    fa_vec_t          stim_vec;
    fa_exp_t          push_data;
    fa_exp_t          head;
    fa_rsp_t          rsp_got;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic             orphan;
    logic             match;
    logic             enter_run;

    // Saturating counter step.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign stim_vec  = '{a: stim_a, b: stim_b, ci: stim_ci};
    assign push_data = '{vec: stim_vec, rsp: fa_ref(stim_vec)};
    assign rsp_got   = '{cry: rsp_cry, s: rsp_s};

    // Ready depends only on registered state, never on stim_vld.
    assign stim_rdy  = (state == S_RUN) && !full && (accepted < NUM_VEC_C);
    assign accept    = stim_vld && stim_rdy;
    assign pop       = (state == S_RUN) && rsp_vld && !empty;
    assign orphan    = (state == S_RUN) && rsp_vld && empty;
    assign match     = (rsp_got == head.rsp);
    assign enter_run = start && (state != S_RUN);

    fa_exp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (enter_run),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Run-control FSM with scoring counters, first-failure capture and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            done           <= 1'b0;
            accepted       <= '0;
            checked        <= '0;
            tmo_cnt        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
            err            <= 1'b0;
            orphan_err     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        done           <= 1'b0;
                        accepted       <= '0;
                        checked        <= '0;
                        tmo_cnt        <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_vec <= '0;
                        err            <= 1'b0;
                        orphan_err     <= 1'b0;
                        timeout_err    <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        accepted <= sat_inc(accepted);
                    end

                    if (pop) begin
                        checked <= sat_inc(checked);
                        if (match) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                            err      <= 1'b1;
                            if (fail_cnt == '0) begin
                                first_fail_idx <= checked;
                                first_fail_vec <= {head.vec.a, head.vec.b, head.vec.ci,
                                                   rsp_s, rsp_cry};
                            end
                        end
                    end

                    if (orphan) begin
                        orphan_err <= 1'b1;
                        err        <= 1'b1;
                    end

                    // Watchdog only runs while results are outstanding and none arrive.
                    if (!empty && !rsp_vld) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= '0;
                    end

                    if (pop && (checked == LAST_IDX)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (!empty && !rsp_vld && (tmo_cnt == TMO_LAST)) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        err         <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_resp_checker.sv
// Directed testbench for fa_resp_checker.
module tb_fa_resp_checker;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stim_vld;
    logic             stim_rdy;
    logic             stim_a;
    logic             stim_b;
    logic             stim_ci;
    logic             rsp_vld;
    logic             rsp_s;
    logic             rsp_cry;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [4:0]       first_fail_vec;
    logic             err;
    logic             orphan_err;
    logic             timeout_err;
    logic             done;

    int checks;
    int failures;

    // Hand-computed {cry,s} for {a,b,ci} = 0..7
    logic [1:0] exp_tbl [8];

    fa_resp_checker #(
        .NUM_VECTORS (8),
        .DEPTH       (4),
        .CNT_W       (CNT_W),
        .TIMEOUT     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stim_vld       (stim_vld),
        .stim_rdy       (stim_rdy),
        .stim_a         (stim_a),
        .stim_b         (stim_b),
        .stim_ci        (stim_ci),
        .rsp_vld        (rsp_vld),
        .rsp_s          (rsp_s),
        .rsp_cry        (rsp_cry),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vec (first_fail_vec),
        .err            (err),
        .orphan_err     (orphan_err),
        .timeout_err    (timeout_err),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input logic [2:0] v);
        stim_a  = v[2];
        stim_b  = v[1];
        stim_ci = v[0];
    endtask

    task automatic push(input logic [2:0] v);
        set_vec(v);
        stim_vld = 1'b1;
        tick();
        stim_vld = 1'b0;
    endtask

    task automatic respond(input logic [1:0] r);
        rsp_vld = 1'b1;
        {rsp_cry, rsp_s} = r;
        tick();
        rsp_vld = 1'b0;
    endtask

    task automatic push_respond(input logic [2:0] v, input logic [1:0] r);
        set_vec(v);
        stim_vld = 1'b1;
        rsp_vld  = 1'b1;
        {rsp_cry, rsp_s} = r;
        tick();
        stim_vld = 1'b0;
        rsp_vld  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_all(input int bad_idx, input logic [1:0] bad_rsp);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rdy_before_push%0d", i), stim_rdy, 1);
            push(3'(i));
            respond((i == bad_idx) ? bad_rsp : exp_tbl[i]);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_pass"},    pass_cnt, 0);
        chk({pfx, "_fail"},    fail_cnt, 0);
        chk({pfx, "_ffidx"},   first_fail_idx, 0);
        chk({pfx, "_ffvec"},   first_fail_vec, 0);
        chk({pfx, "_err"},     err, 0);
        chk({pfx, "_orphan"},  orphan_err, 0);
        chk({pfx, "_timeout"}, timeout_err, 0);
        chk({pfx, "_done"},    done, 0);
        chk({pfx, "_rdy"},     stim_rdy, 0);
    endtask

    initial begin
        exp_tbl[0] = 2'b00; exp_tbl[1] = 2'b01; exp_tbl[2] = 2'b01; exp_tbl[3] = 2'b10;
        exp_tbl[4] = 2'b01; exp_tbl[5] = 2'b10; exp_tbl[6] = 2'b10; exp_tbl[7] = 2'b11;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stim_vld = 1'b0;
        rsp_vld  = 1'b0;
        rsp_s    = 1'b0;
        rsp_cry  = 1'b0;
        set_vec(3'b000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // All-correct run
        pulse_start();
        chk("t1_done_low", done, 0);
        run_all(-1, 2'b00);
        chk("t1_pass", pass_cnt, 8);
        chk("t1_fail", fail_cnt, 0);
        chk("t1_err", err, 0);
        chk("t1_done", done, 1);
        chk("t1_rdy_done", stim_rdy, 0);

        // Responses in DONE are ignored
        respond(2'b11);
        chk("idle_rsp_err", err, 0);
        chk("idle_rsp_orphan", orphan_err, 0);
        chk("idle_rsp_pass", pass_cnt, 8);

        // Wrong response to vector 3 (a=0,b=1,ci=1): s=1,cry=1
        pulse_start();
        chk("t2_cleared_pass", pass_cnt, 0);
        chk("t2_done_low", done, 0);
        run_all(3, 2'b11);
        chk("t2_fail", fail_cnt, 1);
        chk("t2_pass", pass_cnt, 7);
        chk("t2_ffidx", first_fail_idx, 3);
        chk("t2_ffvec", first_fail_vec, 5'b01111);
        chk("t2_err", err, 1);
        chk("t2_done", done, 1);

        // Back-pressure: four pushes fill the FIFO
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rdy%0d", i), stim_rdy, 1);
            push(3'(i));
        end
        chk("t3_rdy_full", stim_rdy, 0);
        push(3'd4);
        chk("t3_rdy_still_full", stim_rdy, 0);
        for (int i = 0; i < 4; i++) begin
            respond(exp_tbl[i]);
        end
        chk("t3_pass4", pass_cnt, 4);
        chk("t3_rdy_drained", stim_rdy, 1);
        push(3'd4);
        for (int i = 5; i < 8; i++) begin
            push_respond(3'(i), exp_tbl[i-1]);
        end
        respond(exp_tbl[7]);
        chk("t3_pass", pass_cnt, 8);
        chk("t3_fail", fail_cnt, 0);
        chk("t3_orphan", orphan_err, 0);
        chk("t3_done", done, 1);

        // Orphan response with empty FIFO
        pulse_start();
        respond(2'b01);
        chk("t4_orphan", orphan_err, 1);
        chk("t4_err", err, 1);
        chk("t4_pass", pass_cnt, 0);
        chk("t4_fail", fail_cnt, 0);
        chk("t4_done", done, 0);

        // Timeout: one vector, response withheld
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_start();
        push(3'd5);
        repeat (15) tick();
        chk("t5_no_tmo_yet", timeout_err, 0);
        chk("t5_not_done_yet", done, 0);
        tick();
        chk("t5_timeout", timeout_err, 1);
        chk("t5_err", err, 1);
        chk("t5_done", done, 1);
        chk("t5_rdy", stim_rdy, 0);

        // Reset mid-run, then a clean run
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            push(3'(i));
            respond(exp_tbl[i]);
        end
        chk("t6_pass3", pass_cnt, 3);
        push(3'd3);
        respond(2'b00);
        chk("t6_fail_pre_rst", fail_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t6_rst");
        pulse_start();
        run_all(-1, 2'b00);
        chk("t6_pass", pass_cnt, 8);
        chk("t6_fail", fail_cnt, 0);
        chk("t6_orphan", orphan_err, 0);
        chk("t6_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fa_resp_checker.md
Name: fa_resp_checker

Overview:
- Synthesizable response-side checker for the full-adder interface (a, b, ci -> s, cry).
- Accepts stimulus vectors over a valid/ready handshake and computes the expected {cry,s} for each accepted vector.
- Queues expected results in order and compares each DUT response against the oldest queued expectation.
- Reports pass/fail counts, first-failure capture, orphan/timeout errors and a done flag, so a run completes without waveform inspection.

Parameters:
- NUM_VECTORS, 8, vectors per run; done asserts after this many responses are checked.
- DEPTH, 4, expected-result FIFO depth (power of 2, >=2).
- CNT_W, 8, width of pass/fail/index counters; NUM_VECTORS must be < 2**CNT_W.
- TIMEOUT, 16, max cycles in RUN with FIFO non-empty and no response before timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a run from IDLE or DONE
- stim_vld  in  1  stimulus valid
- stim_rdy  out  1  stimulus ready
- stim_a, stim_b, stim_ci  in  1 each  stimulus bits
- rsp_vld  in  1  DUT response valid (checker always accepts)
- rsp_s, rsp_cry  in  1 each  DUT sum/carry
- pass_cnt  out  CNT_W  matching responses
- fail_cnt  out  CNT_W  mismatching responses
- first_fail_idx  out  CNT_W  response index (0-based) of first mismatch
- first_fail_vec  out  5  {a,b,ci,s_got,cry_got} of first mismatch
- err  out  1  sticky: any mismatch, orphan or timeout
- orphan_err  out  1  sticky: response arrived with FIFO empty
- timeout_err  out  1  sticky: TIMEOUT expired
- done  out  1  high in DONE state

Behaviour:
- Reset: state=IDLE; all outputs 0; FIFO empty; accepted and checked counters 0.
- The reset value of stim_rdy is 0. A reset in any state, including mid-run, aborts the run and restores the reset values on the next edge.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when checked==NUM_VECTORS, or on timeout.
  - DONE -> RUN on start.
  - start in RUN is ignored.
- Entering RUN clears the counters, the capture registers, the sticky errors and the FIFO.
- stim_rdy = (state==RUN) && !full && (accepted<NUM_VECTORS). It is registered-state derived and has no combinational path from stim_vld.
- Stimulus accept = stim_vld && stim_rdy.
  - Pushes {a,b,ci,cry_exp,s_exp} with s_exp=a^b^ci and cry_exp=(a&b)|(ci&(a^b)).
  - accepted increments on each accept.
- A response in RUN with FIFO non-empty pops the head and compares {rsp_cry,rsp_s} with the expected value.
  - Match: pass_cnt+1.
  - Mismatch: fail_cnt+1 and err=1.
  - If fail_cnt was 0 before this mismatch, first_fail_idx=checked and first_fail_vec={head a,b,ci,rsp_s,rsp_cry}.
  - checked increments on every pop; pass_cnt/fail_cnt/first_fail_* update on the clock edge after the response.
- A response in RUN with FIFO empty sets orphan_err=1 and err=1. No pop, no count change.
  - There is no bypass: a push and an orphan response in the same cycle still count as orphan, and the push completes.
- A simultaneous push and pop with FIFO non-empty keeps occupancy unchanged. A push into a full FIFO cannot occur because stim_rdy=0.
- Responses in IDLE or DONE are ignored with no error.
- Timeout counter:
  - Increments each RUN cycle with FIFO non-empty and no rsp_vld.
  - Clears on rsp_vld or when the FIFO is empty.
  - Reaching TIMEOUT sets timeout_err=1 and err=1, and the state goes to DONE.
- Checking latency: a response at cycle N is reflected in counters at N+1. done asserts the cycle after the final pop.
- Counters saturate at 2**CNT_W-1.

Decomposition:
- Package fa_chk_pkg:
  - fa_vec_t (packed a,b,ci)
  - fa_rsp_t (packed cry,s)
  - fa_exp_t (vec+rsp)
  - chk_state_e {IDLE,RUN,DONE}
  - function fa_ref(fa_vec_t) returning fa_rsp_t
- Sub-module fa_exp_fifo:
  - synchronous FIFO of fa_exp_t with parameter DEPTH
  - ports push/pop/clr, full/empty, head data
  - pointer wrap uses an extra MSB for full/empty distinction

Test Plan:
- start; push 8 vectors 000..111; return correct {cry,s} one cycle after each push -> pass_cnt=8, fail_cnt=0, err=0, done=1.
- Same 8 vectors, but the response to vector 3 (a=0,b=1,ci=1) is s=1,cry=1 -> fail_cnt=1, pass_cnt=7, first_fail_idx=3, first_fail_vec=5'b01111, err=1.
- Hold rsp_vld=0 while pushing -> stim_rdy drops after 4 accepts (DEPTH=4). Then release responses -> all 8 vectors are checked with no orphan.
- rsp_vld pulse right after start, with FIFO empty -> orphan_err=1, err=1, pass_cnt=0.
- Push 1 vector and withhold the response for 16 cycles -> timeout_err=1, done=1, state DONE.
- Assert rst after 3 responses, then start again -> all outputs are 0 after reset, and the new run completes with pass_cnt=8.
